// File: rtl/spiflash_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spiflash_responder
//
// Synthesizable single-lane SPI flash slave that serves boot firmware out of a
// synchronous ROM/RAM read port. The SoC flash pins are asynchronous to clk and
// are oversampled through 2-FF synchronisers; SPI mode 0 only.
//
// Supported commands:
//   0x03 READ      24-bit address, then streaming data with auto-increment
//   0x9F JEDEC ID  three ID bytes MSB first, then zeros
//   0xAB           release from power-down
//   0xB9           enter power-down
//   0xFF / other   ignored until chip select rises
//
// Parameters:
//   MEM_AW       byte-address width of the backing memory (must be <= 24)
//   JEDEC_ID     value returned by 0x9F, MSB first
//   PD_AT_RESET  1: powered down after reset, only 0xAB honoured until woken
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   nrst          synchronous active-low reset
//   flash_csb     SPI chip select, active low (asynchronous)
//   flash_clk     SPI clock, mode 0 (asynchronous)
//   flash_io0     MOSI (asynchronous)
//   flash_io1_do  MISO data
//   flash_io1_oe  MISO output enable (pad tristated when 0)
//   mem_rd        one-cycle read strobe to the backing memory
//   mem_addr      byte address to the backing memory
//   mem_rdata     read data, valid exactly one clk after mem_rd
//   powered_down  status: device is in power-down
//
// The SPI clock must stay high and low for at least 4 clk cycles each; the
// fetch pipeline relies on that to have a byte ready before it is needed.
// -----------------------------------------------------------------------------
module spiflash_responder #(
   parameter int          MEM_AW      = 20,
   parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
   parameter bit          PD_AT_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              flash_csb,
   input  logic              flash_clk,
   input  logic              flash_io0,
   output logic              flash_io1_do,
   output logic              flash_io1_oe,
   output logic              mem_rd,
   output logic [MEM_AW-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic              powered_down
);

   // --------------------------------------------------------------------------
   // FSM encoding and command opcodes
   // --------------------------------------------------------------------------
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CMD    = 3'd1;
   localparam logic [2:0] ST_ADDR   = 3'd2;
   localparam logic [2:0] ST_FETCH  = 3'd3;
   localparam logic [2:0] ST_DATA   = 3'd4;
   localparam logic [2:0] ST_ID     = 3'd5;
   localparam logic [2:0] ST_IGNORE = 3'd6;

   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_JEDEC = 8'h9F;
   localparam logic [7:0] CMD_WAKE  = 8'hAB;
   localparam logic [7:0] CMD_SLEEP = 8'hB9;

   // --------------------------------------------------------------------------
   // Pin synchronisers and SCK edge detection
   // --------------------------------------------------------------------------
   logic csb_meta_q, csb_sync_q;
   logic sck_meta_q, sck_sync_q, sck_prev_q;
   logic mosi_meta_q, mosi_sync_q;
   logic sck_rise, sck_fall;

   // MOSI goes through the same two-stage delay as SCK, so the bit seen on a
   // detected rise is the one the master presented at the pin rise.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples
      // the pre-edge value of its neighbours, independent of statement order.
      if (!nrst) begin
         csb_meta_q  <= 1'b1;
         csb_sync_q  <= 1'b1;
         sck_meta_q  <= 1'b0;
         sck_sync_q  <= 1'b0;
         sck_prev_q  <= 1'b0;
         mosi_meta_q <= 1'b0;
         mosi_sync_q <= 1'b0;
      end else begin
         csb_meta_q  <= flash_csb;
         csb_sync_q  <= csb_meta_q;
         sck_meta_q  <= flash_clk;
         sck_sync_q  <= sck_meta_q;
         sck_prev_q  <= sck_sync_q;
         mosi_meta_q <= flash_io0;
         mosi_sync_q <= mosi_meta_q;
      end
   end

   assign sck_rise = sck_sync_q & ~sck_prev_q;
   assign sck_fall = ~sck_sync_q & sck_prev_q;

   // --------------------------------------------------------------------------
   // Protocol state
   // --------------------------------------------------------------------------
   logic [2:0]        state_q,    state_d;
   logic [4:0]        bit_cnt_q,  bit_cnt_d;   // bits shifted in (CMD/ADDR) or driven (DATA)
   logic [23:0]       shift_q,    shift_d;     // command/address in, JEDEC ID out
   logic [7:0]        tx_q,       tx_d;        // current data byte
   logic              hold_q,     hold_d;      // first fall after a preload keeps the bit
   logic              do_q,       do_d;
   logic              oe_q,       oe_d;
   logic              mem_rd_q,   mem_rd_d;
   logic              rd_dly_q,   rd_dly_d;    // mem_rdata is valid while this is set
   logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
   logic              pd_q,       pd_d;
   logic [23:0]       shift_nxt;               // shift_q with the current MOSI bit appended

   always_comb begin
      // NOTE: every *_d is given its hold value first, so no branch can leave
      // a signal unassigned and infer a latch.
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      hold_d     = hold_q;
      do_d       = do_q;
      oe_d       = oe_q;
      mem_rd_d   = 1'b0;
      rd_dly_d   = mem_rd_q;
      mem_addr_d = mem_addr_q;
      pd_d       = pd_q;
      shift_nxt  = {shift_q[22:0], mosi_sync_q};

      // Every read lands in tx one cycle after its strobe. In DATA this
      // overwrites a byte whose last bit already sits in do_q.
      if (rd_dly_q) begin
         tx_d = mem_rdata;
      end

      if (csb_sync_q) begin
         // Deselect wins over everything, including a coincident SCK rise, so
         // a partial command or address never has side effects.
         state_d   = ST_IDLE;
         bit_cnt_d = 5'd0;
         hold_d    = 1'b0;
         do_d      = 1'b0;
         oe_d      = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d   = ST_CMD;
               bit_cnt_d = 5'd0;
            end

            ST_CMD: begin
               if (sck_rise) begin
                  shift_d   = shift_nxt;
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd7) begin
                     bit_cnt_d = 5'd0;
                     state_d   = ST_IGNORE;
                     case (shift_nxt[7:0])
                        CMD_READ: begin
                           if (!pd_q) begin
                              state_d = ST_ADDR;
                           end
                        end
                        CMD_JEDEC: begin
                           if (!pd_q) begin
                              // Preload the first ID bit; the master samples it
                              // on the rise after the next fall.
                              state_d = ST_ID;
                              shift_d = JEDEC_ID;
                              oe_d    = 1'b1;
                              do_d    = JEDEC_ID[23];
                              hold_d  = 1'b1;
                           end
                        end
                        CMD_WAKE:  pd_d = 1'b0;
                        CMD_SLEEP: pd_d = 1'b1;
                        default:   state_d = ST_IGNORE;
                     endcase
                  end
               end
            end

            ST_ADDR: begin
               if (sck_rise) begin
                  shift_d   = shift_nxt;
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd23) begin
                     bit_cnt_d  = 5'd0;
                     mem_addr_d = shift_nxt[MEM_AW-1:0];
                     mem_rd_d   = 1'b1;
                     state_d    = ST_FETCH;
                  end
               end
            end

            ST_FETCH: begin
               // First byte arrives two cycles after the address completes,
               // well inside the SCK high phase.
               if (rd_dly_q) begin
                  state_d   = ST_DATA;
                  oe_d      = 1'b1;
                  do_d      = mem_rdata[7];
                  bit_cnt_d = 5'd0;
                  hold_d    = 1'b1;
               end
            end

            ST_DATA: begin
               // bit_cnt counts bits already driven minus one: 7 means bit 0
               // is on the wire, so prefetch the next byte while the master
               // samples it and switch bytes on the following fall.
               if (sck_rise && bit_cnt_q == 5'd7) begin
                  mem_addr_d = mem_addr_q + MEM_AW'(1);
                  mem_rd_d   = 1'b1;
               end
               if (sck_fall) begin
                  if (hold_q) begin
                     hold_d = 1'b0;
                  end else if (bit_cnt_q == 5'd7) begin
                     do_d      = tx_q[7];
                     bit_cnt_d = 5'd0;
                  end else begin
                     do_d      = tx_q[3'd6 - bit_cnt_q[2:0]];
                     bit_cnt_d = bit_cnt_q + 5'd1;
                  end
               end
            end

            ST_ID: begin
               // Zeros shift in behind the ID, giving 0x00 after byte three.
               if (sck_fall) begin
                  if (hold_q) begin
                     hold_d = 1'b0;
                  end else begin
                     do_d    = shift_q[22];
                     shift_d = {shift_q[22:0], 1'b0};
                  end
               end
            end

            ST_IGNORE: begin
               oe_d = 1'b0;
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 5'd0;
         shift_q    <= 24'd0;
         tx_q       <= 8'd0;
         hold_q     <= 1'b0;
         do_q       <= 1'b0;
         oe_q       <= 1'b0;
         mem_rd_q   <= 1'b0;
         rd_dly_q   <= 1'b0;
         mem_addr_q <= '0;
         pd_q       <= PD_AT_RESET;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         hold_q     <= hold_d;
         do_q       <= do_d;
         oe_q       <= oe_d;
         mem_rd_q   <= mem_rd_d;
         rd_dly_q   <= rd_dly_d;
         mem_addr_q <= mem_addr_d;
         pd_q       <= pd_d;
      end
   end

   assign flash_io1_do = do_q;
   assign flash_io1_oe = oe_q;
   assign mem_rd       = mem_rd_q;
   assign mem_addr     = mem_addr_q;
   assign powered_down = pd_q;

endmodule

// File: tb/tb_spiflash_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_spiflash_responder
//
// Drives the flash pins as a mode-0 SPI master (half period 60 ns = 6 clk),
// models a synchronous byte memory, and compares returned MISO bytes against a
// scoreboard queue filled when each read is issued.
// -----------------------------------------------------------------------------
module tb_spiflash_responder;

   localparam int MEM_AW = 20;
   localparam int HALF   = 60;

   logic              clk;
   logic              nrst;
   logic              flash_csb;
   logic              flash_clk;
   logic              flash_io0;
   logic              flash_io1_do;
   logic              flash_io1_oe;
   logic              mem_rd;
   logic [MEM_AW-1:0] mem_addr;
   logic [7:0]        mem_rdata = 8'h00;
   logic              powered_down;

   spiflash_responder #(
      .MEM_AW      (MEM_AW),
      .JEDEC_ID    (24'hEF4018),
      .PD_AT_RESET (1'b1)
   ) dut (
      .clk          (clk),
      .nrst         (nrst),
      .flash_csb    (flash_csb),
      .flash_clk    (flash_clk),
      .flash_io0    (flash_io0),
      .flash_io1_do (flash_io1_do),
      .flash_io1_oe (flash_io1_oe),
      .mem_rd       (mem_rd),
      .mem_addr     (mem_addr),
      .mem_rdata    (mem_rdata),
      .powered_down (powered_down)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: three fixed bytes, a position-dependent pattern elsewhere
   function automatic logic [7:0] mem_byte(input logic [MEM_AW-1:0] a);
      case (a)
         20'h00010: return 8'hA5;
         20'h00011: return 8'h3C;
         20'h00012: return 8'h7E;
         default:   return (a[7:0] + a[15:8]) ^ 8'h5A;
      endcase
   endfunction

   always @(posedge clk) begin
      if (mem_rd) mem_rdata <= mem_byte(mem_addr);
   end

   // Bus monitors
   int                rd_cnt = 0;
   int                oe_cnt = 0;
   logic [MEM_AW-1:0] addr_log[$];

   always @(posedge clk) begin
      if (mem_rd) begin
         rd_cnt <= rd_cnt + 1;
         addr_log.push_back(mem_addr);
      end
      if (flash_io1_oe) oe_cnt <= oe_cnt + 1;
   end

   // Checking
   int         errors = 0;
   int         checks = 0;
   logic [7:0] sb_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Shift n bits (MSB first from data[n-1:0]); MISO sampled just before each rise
   task automatic spi_bits(input logic [31:0] data, input int n, output logic [31:0] rx);
      rx = '0;
      for (int i = n - 1; i >= 0; i--) begin
         flash_io0 = data[i];
         #HALF;
         rx[i]     = flash_io1_do;
         flash_clk = 1'b1;
         #HALF;
         flash_clk = 1'b0;
      end
   endtask

   task automatic select();
      flash_csb = 1'b0;
      #HALF;
   endtask

   task automatic deselect();
      #HALF;
      flash_csb = 1'b1;
      #100;
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic [31:0] rx;
      spi_bits({24'h0, b}, 8, rx);
   endtask

   // Clock in one byte and compare with the oldest scoreboard entry
   task automatic read_byte(input string tag);
      logic [31:0] rx;
      logic [7:0]  exp;
      spi_bits(32'h0, 8, rx);
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: got 0x%0h, expected nothing (scoreboard empty)", tag, rx[7:0]);
      end else begin
         exp = sb_q.pop_front();
         check(tag, {24'h0, rx[7:0]}, {24'h0, exp});
      end
   endtask

   task automatic cmd_only(input logic [7:0] c);
      select();
      send_byte(c);
      deselect();
   endtask

   task automatic watch_reset_values(input string tag);
      check({tag, "_do"},   32'(flash_io1_do), 32'd0);
      check({tag, "_oe"},   32'(flash_io1_oe), 32'd0);
      check({tag, "_rd"},   32'(mem_rd),       32'd0);
      check({tag, "_addr"}, 32'(mem_addr),     32'd0);
      check({tag, "_pd"},   32'(powered_down), 32'd1);
   endtask

   typedef struct packed {
      logic [7:0]  cmd;
      logic        has_addr;
      logic [23:0] addr;
      logic [2:0]  nbytes;
      logic [31:0] exp_bytes;   // expected MISO bytes, first in [31:24]
      logic        exp_oe;      // MISO enabled at some point
      logic        exp_pd;      // powered_down afterwards
      logic [3:0]  exp_rds;     // mem_rd pulses during the transaction
   } vec_t;

   localparam int NVEC = 10;
   vec_t vecs[NVEC];

   initial begin
      #400_000;
      $display("FAIL watchdog: simulation exceeded time limit, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        v;
      logic [31:0] ebytes;
      logic [31:0] rx;
      logic [7:0]  b;
      logic [MEM_AW-1:0] a_exp;
      int          rd0, oe0, log0;
      string       tag;

      // Streaming reads fetch one byte beyond the last one clocked out.
      vecs[0] = '{8'h03, 1'b1, 24'h000010, 3'd1, 32'h0,           1'b0, 1'b1, 4'd0};
      vecs[1] = '{8'hFF, 1'b0, 24'h0,      3'd0, 32'h0,           1'b0, 1'b1, 4'd0};
      vecs[2] = '{8'hAB, 1'b0, 24'h0,      3'd0, 32'h0,           1'b0, 1'b0, 4'd0};
      vecs[3] = '{8'h03, 1'b1, 24'h000010, 3'd3, 32'hA53C7E00,    1'b1, 1'b0, 4'd4};
      vecs[4] = '{8'h9F, 1'b0, 24'h0,      3'd4, 32'hEF401800,    1'b1, 1'b0, 4'd0};
      vecs[5] = '{8'h03, 1'b1, 24'h0FFFFF, 3'd2,
                  {mem_byte(20'hFFFFF), mem_byte(20'h00000), 16'h0}, 1'b1, 1'b0, 4'd3};
      vecs[6] = '{8'hB9, 1'b0, 24'h0,      3'd0, 32'h0,           1'b0, 1'b1, 4'd0};
      vecs[7] = '{8'h03, 1'b1, 24'h000010, 3'd1, 32'h0,           1'b0, 1'b1, 4'd0};
      vecs[8] = '{8'hAB, 1'b0, 24'h0,      3'd0, 32'h0,           1'b0, 1'b0, 4'd0};
      vecs[9] = '{8'h03, 1'b1, 24'h000011, 3'd2, 32'h3C7E0000,    1'b1, 1'b0, 4'd3};

      nrst      = 1'b0;
      flash_csb = 1'b1;
      flash_clk = 1'b0;
      flash_io0 = 1'b0;
      #50;
      watch_reset_values("reset");
      #50;
      nrst = 1'b1;
      #50;

      // ---- table-driven transactions ----
      for (int i = 0; i < NVEC; i++) begin
         v    = vecs[i];
         rd0  = rd_cnt;
         oe0  = oe_cnt;
         log0 = addr_log.size();
         select();
         send_byte(v.cmd);
         if (v.has_addr) spi_bits({8'h0, v.addr}, 24, rx);
         ebytes = v.exp_bytes;
         for (int k = 0; k < int'(v.nbytes); k++) begin
            sb_q.push_back(ebytes[31:24]);
            ebytes = ebytes << 8;
            read_byte($sformatf("v%0d_byte%0d", i, k));
         end
         deselect();
         check($sformatf("v%0d_pd", i),    32'(powered_down),        32'(v.exp_pd));
         check($sformatf("v%0d_oe", i),    32'(oe_cnt != oe0),       32'(v.exp_oe));
         check($sformatf("v%0d_rds", i),   32'(rd_cnt - rd0),        32'(v.exp_rds));
         check($sformatf("v%0d_idle", i),  {30'h0, flash_io1_oe, flash_io1_do}, 32'h0);
         if (v.exp_rds > 0) begin
            a_exp = v.addr[MEM_AW-1:0];
            check($sformatf("v%0d_addr0", i), 32'(addr_log[log0]), 32'(a_exp));
            a_exp = a_exp + 20'd1;
            check($sformatf("v%0d_addr1", i), 32'(addr_log[log0 + 1]), 32'(a_exp));
         end
      end

      // ---- abort after 13 address bits, then a clean ID read ----
      rd0 = rd_cnt;
      select();
      send_byte(8'h03);
      spi_bits(32'h0000_0123, 13, rx);
      flash_csb = 1'b1;
      #40;
      check("abort_addr_oe", 32'(flash_io1_oe), 32'd0);
      #100;
      check("abort_addr_rds", 32'(rd_cnt - rd0), 32'd0);
      select();
      send_byte(8'h9F);
      sb_q.push_back(8'hEF); read_byte("abort_id0");
      sb_q.push_back(8'h40); read_byte("abort_id1");
      sb_q.push_back(8'h18); read_byte("abort_id2");
      deselect();

      // ---- abort mid ID byte while MISO is enabled ----
      select();
      send_byte(8'h9F);
      spi_bits(32'h0, 12, rx);
      check("midid_oe_on", 32'(flash_io1_oe), 32'd1);
      flash_csb = 1'b1;
      #40;
      check("midid_off", {30'h0, flash_io1_oe, flash_io1_do}, 32'h0);
      #100;

      // ---- short power-down command: 5 bits only ----
      select();
      spi_bits(32'h17, 5, rx);
      deselect();
      check("short_cmd_pd", 32'(powered_down), 32'd0);

      // ---- deselect coincident with the 8th rise of 0xB9 ----
      select();
      spi_bits(32'h5C, 7, rx);
      flash_io0 = 1'b1;
      #HALF;
      flash_csb = 1'b1;
      flash_clk = 1'b1;
      #HALF;
      flash_clk = 1'b0;
      #100;
      check("coincident_pd", 32'(powered_down), 32'd0);
      cmd_only(8'hB9);
      check("b9_pd", 32'(powered_down), 32'd1);
      cmd_only(8'hAB);
      check("ab_pd", 32'(powered_down), 32'd0);

      // ---- reset in the middle of a data byte ----
      select();
      send_byte(8'h03);
      spi_bits(32'h0000_0010, 24, rx);
      sb_q.push_back(8'hA5);
      read_byte("rst_byte0");
      spi_bits(32'h0, 3, rx);
      check("rst_pre_oe", 32'(flash_io1_oe), 32'd1);
      nrst = 1'b0;
      #30;
      watch_reset_values("midrst");
      flash_csb = 1'b1;
      #50;
      nrst = 1'b1;
      #100;
      check("post_rst_pd", 32'(powered_down), 32'd1);

      // ---- wake and read again after the reset ----
      cmd_only(8'hAB);
      select();
      send_byte(8'h03);
      spi_bits(32'h0000_0012, 24, rx);
      sb_q.push_back(8'h7E);
      read_byte("post_rst_byte");
      deselect();
      check("post_rst_pd_woken", 32'(powered_down), 32'd0);
      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
